zion_riscv_isa_lib_bits_ex_sched: RTL and testbench

Two-requester scheduler for the shared RISC-V bit-operation unit (AND/ANDI, OR/ORI, XOR/XORI). Two issue lanes request bit operations through valid/ready handshakes. A round-robin arbiter grants one request per cycle into a two-stage elastic pipeline (operand latch, result register). The response port delivers the result, the tag and the source lane under valid/ready backpressure. The block sits between the dual-issue decode stage and writeback, so one bit-op datapath serves both lanes.

---
 rtl/zion_riscv_isa_lib_bits_ex_sched_if.sv | 43 ++++
 rtl/zion_riscv_isa_lib_bits_ex_sched.sv | 151 +++++++++++++++
 tb/tb_zion_riscv_isa_lib_bits_ex_sched.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/zion_riscv_isa_lib_bits_ex_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : zion_riscv_isa_lib_bits_ex_sched_if
// Purpose  : Request/response bundle for the shared bit-op scheduler.
//            Two issue lanes present ops (valid/ready). One response
//            channel returns result, tag and source lane (valid/ready).
// Ports    : iReqVld/oReqRdy/iReqOp/iReqS1/iReqS2/iReqTag  per-lane request
//            iFlush                                       pipeline flush
//            oRspVld/iRspRdy/oRspRslt/oRspTag/oRspSrc/oRspErr  response
// Modports : master - issue/writeback side; slave - the scheduler
// Revision : 1.0 - initial release
// ============================================================================
interface zion_riscv_isa_lib_bits_ex_sched_if #(
   parameter int RV64  = 0,
   parameter int TAG_W = 4
);
   localparam int CPU_WIDTH = 32 * (RV64 + 1);

   logic [1:0]                  iReqVld;
   logic [1:0]                  oReqRdy;
   logic [1:0][1:0]             iReqOp;
   logic [1:0][CPU_WIDTH-1:0]   iReqS1;
   logic [1:0][CPU_WIDTH-1:0]   iReqS2;
   logic [1:0][TAG_W-1:0]       iReqTag;
   logic                        iFlush;
   logic                        oRspVld;
   logic                        iRspRdy;
   logic [CPU_WIDTH-1:0]        oRspRslt;
   logic [TAG_W-1:0]            oRspTag;
   logic                        oRspSrc;
   logic                        oRspErr;

   modport master (
      output iReqVld, iReqOp, iReqS1, iReqS2, iReqTag, iFlush, iRspRdy,
      input  oReqRdy, oRspVld, oRspRslt, oRspTag, oRspSrc, oRspErr
   );

   modport slave (
      input  iReqVld, iReqOp, iReqS1, iReqS2, iReqTag, iFlush, iRspRdy,
      output oReqRdy, oRspVld, oRspRslt, oRspTag, oRspSrc, oRspErr
   );
endinterface
`default_nettype wire

// File: rtl/zion_riscv_isa_lib_bits_ex_sched.sv
`default_nettype none
// ============================================================================
// Module   : zion_riscv_isa_lib_bits_ex_sched
// Purpose  : Round-robin scheduler feeding one AND/OR/XOR datapath from two
//            issue lanes through a two-stage elastic pipeline
//            (S1 operand latch, S2 result register driving the response).
// Ports    : iClk  - clock
//            iRst  - synchronous active-high reset
//            bus   - request/response bundle (slave modport)
// Revision : 1.0 - initial release
// ============================================================================
module zion_riscv_isa_lib_bits_ex_sched #(
   parameter int RV64  = 0,
   parameter int TAG_W = 4
) (
   input  wire logic                      iClk,
   input  wire logic                      iRst,
   zion_riscv_isa_lib_bits_ex_sched_if.slave bus
);
   localparam int CPU_WIDTH = 32 * (RV64 + 1);

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;

   // S1 operand latch
   logic                  rS1Vld;
   logic [1:0]            rS1Op;
   logic [CPU_WIDTH-1:0]  rS1A;
   logic [CPU_WIDTH-1:0]  rS1B;
   logic [TAG_W-1:0]      rS1Tag;
   logic                  rS1Src;

   // S2 result register, drives the response port directly
   logic                  rS2Vld;
   logic [CPU_WIDTH-1:0]  rS2Rslt;
   logic [TAG_W-1:0]      rS2Tag;
   logic                  rS2Src;
   logic                  rS2Err;

   logic                  rRrPtr;

   logic                  wS2Adv;
   logic                  wS1Adv;
   logic                  wCanGrant;
   logic [1:0]            wGrant;
   logic                  wHs;
   logic                  wSel;
   logic [CPU_WIDTH-1:0]  wRslt;
   logic                  wErr;

   assign wS2Adv    = !rS2Vld || bus.iRspRdy;
   assign wS1Adv    = !rS1Vld || wS2Adv;
   // Reset gating keeps ready low for the whole reset cycle.
   assign wCanGrant = wS1Adv && !bus.iFlush && !iRst;

   // Contention goes to the lane named by rRrPtr; a lone requester always wins.
   always_comb begin
      wGrant = 2'b00;
      if (wCanGrant) begin
         if (bus.iReqVld == 2'b11) begin
            wGrant[rRrPtr] = 1'b1;
         end else begin
            wGrant = bus.iReqVld;
         end
      end
   end

   assign wHs         = |wGrant;
   assign wSel        = wGrant[1];
   assign bus.oReqRdy = wGrant;

   // Bit-op datapath; the illegal encoding yields zero with the error flag.
   always_comb begin
      wRslt = '0;
      wErr  = 1'b0;
      case (rS1Op)
         OP_AND:  wRslt = rS1A & rS1B;
         OP_OR:   wRslt = rS1A | rS1B;
         OP_XOR:  wRslt = rS1A ^ rS1B;
         default: wErr  = 1'b1;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         rS1Vld  <= 1'b0;
         rS1Op   <= 2'b00;
         rS1A    <= '0;
         rS1B    <= '0;
         rS1Tag  <= '0;
         rS1Src  <= 1'b0;
         rS2Vld  <= 1'b0;
         rS2Rslt <= '0;
         rS2Tag  <= '0;
         rS2Src  <= 1'b0;
         rS2Err  <= 1'b0;
         rRrPtr  <= 1'b0;
      end else begin
         // Valid bits: flush wins over any advance (a consumed response is
         // simply not replaced).
         if (bus.iFlush) begin
            rS1Vld <= 1'b0;
            rS2Vld <= 1'b0;
         end else begin
            if (wS1Adv) begin
               rS1Vld <= wHs;
            end
            if (wS2Adv) begin
               rS2Vld <= rS1Vld;
            end
         end

         // Payloads only move with a live op, so held responses stay stable.
         if (wHs) begin
            rS1Op  <= bus.iReqOp[wSel];
            rS1A   <= bus.iReqS1[wSel];
            rS1B   <= bus.iReqS2[wSel];
            rS1Tag <= bus.iReqTag[wSel];
            rS1Src <= wSel;
            rRrPtr <= ~wSel;
         end

         if (wS2Adv && rS1Vld) begin
            rS2Rslt <= wRslt;
            rS2Tag  <= rS1Tag;
            rS2Src  <= rS1Src;
            rS2Err  <= wErr;
         end
      end
   end

   assign bus.oRspVld  = rS2Vld;
   assign bus.oRspRslt = rS2Rslt;
   assign bus.oRspTag  = rS2Tag;
   assign bus.oRspSrc  = rS2Src;
   assign bus.oRspErr  = rS2Err;

   aRdyOnehot: assert property (@(posedge iClk) disable iff (iRst)
      $onehot0(bus.oReqRdy));

   aNoRdyInFlush: assert property (@(posedge iClk) disable iff (iRst)
      bus.iFlush |-> (bus.oReqRdy == 2'b00));

   aRspHold: assert property (@(posedge iClk) disable iff (iRst)
      (bus.oRspVld && !bus.iRspRdy && !bus.iFlush) |=>
         (bus.oRspVld && $stable(bus.oRspRslt) && $stable(bus.oRspTag) &&
          $stable(bus.oRspSrc) && $stable(bus.oRspErr)));

endmodule
`default_nettype wire

// File: tb/tb_zion_riscv_isa_lib_bits_ex_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_zion_riscv_isa_lib_bits_ex_sched
// Purpose  : Self-checking bench for the bit-op scheduler: table of single
//            ops plus directed sequences for arbitration, backpressure,
//            flush and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zion_riscv_isa_lib_bits_ex_sched;
   logic iClk;
   logic iRst;
   int   compCnt;
   int   failCnt;

   zion_riscv_isa_lib_bits_ex_sched_if #(.RV64(0), .TAG_W(4)) bus ();

   zion_riscv_isa_lib_bits_ex_sched #(.RV64(0), .TAG_W(4)) dut (
      .iClk (iClk),
      .iRst (iRst),
      .bus  (bus.slave)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   typedef struct {
      logic        lane;
      logic [1:0]  op;
      logic [31:0] s1;
      logic [31:0] s2;
      logic [3:0]  tag;
      logic [31:0] expRslt;
      logic        expErr;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compCnt++;
      if (act !== exp) begin
         failCnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   task automatic setLane(input int l, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag);
      bus.iReqOp[l]  = op;
      bus.iReqS1[l]  = a;
      bus.iReqS2[l]  = b;
      bus.iReqTag[l] = tag;
   endtask

   task automatic chkRspZero(input string name);
      chk({name, ".vld"},  bus.oRspVld,  1'b0);
      chk({name, ".rslt"}, bus.oRspRslt, 32'h0);
      chk({name, ".tag"},  bus.oRspTag,  4'h0);
      chk({name, ".src"},  bus.oRspSrc,  1'b0);
      chk({name, ".err"},  bus.oRspErr,  1'b0);
   endtask

   initial begin
      logic [31:0] hRslt;
      compCnt = 0;
      failCnt = 0;

      vecs[0] = '{1'b0, 2'b00, 32'hF0F0_1234, 32'h0FF0_FF00, 4'h3, 32'h00F0_1200, 1'b0};
      vecs[1] = '{1'b0, 2'b01, 32'hF0F0_1234, 32'h0FF0_FF00, 4'h3, 32'hFFF0_FF34, 1'b0};
      vecs[2] = '{1'b0, 2'b10, 32'hF0F0_1234, 32'h0FF0_FF00, 4'h3, 32'hFF00_ED34, 1'b0};
      vecs[3] = '{1'b1, 2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 4'h7, 32'h0000_0000, 1'b1};
      vecs[4] = '{1'b1, 2'b10, 32'hAAAA_5555, 32'h1234_5678, 4'hC, 32'hB89E_032D, 1'b0};
      vecs[5] = '{1'b1, 2'b00, 32'hFFFF_FFFF, 32'h8000_0001, 4'hF, 32'h8000_0001, 1'b0};

      iRst        = 1'b1;
      bus.iReqVld = 2'b11;
      bus.iFlush  = 1'b0;
      bus.iRspRdy = 1'b1;
      setLane(0, 2'b00, 32'h0, 32'h0, 4'h0);
      setLane(1, 2'b00, 32'h0, 32'h0, 4'h0);
      step();
      step();
      chk("rst.rdy", bus.oReqRdy, 2'b00);
      chkRspZero("rst");
      iRst = 1'b0;

      // ---- round-robin with both lanes saturated ----
      setLane(0, 2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'h1);
      setLane(1, 2'b01, 32'h0000_0001, 32'h0000_0010, 4'h2);
      for (int i = 0; i < 5; i++) begin
         bus.iReqVld = (i < 4) ? 2'b11 : 2'b00;
         #1;
         if (i < 4) chk("rr.rdy", bus.oReqRdy, (i % 2 == 0) ? 2'b01 : 2'b10);
         step();
         if (i >= 1) begin
            chk("rr.vld", bus.oRspVld, 1'b1);
            chk("rr.src", bus.oRspSrc, ((i - 1) % 2 == 1) ? 1'b1 : 1'b0);
            chk("rr.rslt", bus.oRspRslt,
                ((i - 1) % 2 == 1) ? 32'h0000_0011 : 32'h0F0F_0000);
            chk("rr.tag", bus.oRspTag, ((i - 1) % 2 == 1) ? 4'h2 : 4'h1);
         end
      end
      step();
      chk("rr.drain", bus.oRspVld, 1'b0);

      // ---- table of single ops ----
      foreach (vecs[k]) begin
         setLane(vecs[k].lane, vecs[k].op, vecs[k].s1, vecs[k].s2, vecs[k].tag);
         setLane(!vecs[k].lane, 2'b01, ~vecs[k].s1, ~vecs[k].s2, ~vecs[k].tag);
         bus.iReqVld = vecs[k].lane ? 2'b10 : 2'b01;
         #1;
         chk("vec.rdy", bus.oReqRdy, vecs[k].lane ? 2'b10 : 2'b01);
         step();
         bus.iReqVld = 2'b00;
         chk("vec.lat", bus.oRspVld, 1'b0);
         step();
         chk("vec.vld",  bus.oRspVld,  1'b1);
         chk("vec.rslt", bus.oRspRslt, vecs[k].expRslt);
         chk("vec.tag",  bus.oRspTag,  vecs[k].tag);
         chk("vec.src",  bus.oRspSrc,  vecs[k].lane);
         chk("vec.err",  bus.oRspErr,  vecs[k].expErr);
         step();
         chk("vec.done", bus.oRspVld, 1'b0);
      end

      // ---- backpressure: 3 ops on lane 0 with the consumer stalled ----
      bus.iRspRdy = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         setLane(0, 2'b01, 32'(i), 32'h100, 4'(i));
         bus.iReqVld = 2'b01;
         #1;
         chk("bp.rdy", bus.oReqRdy, (i <= 2) ? 2'b01 : 2'b00);
         step();
      end
      // op3 still waiting; response 1 must hold
      chk("bp.vld", bus.oRspVld, 1'b1);
      chk("bp.tag1", bus.oRspTag, 4'h1);
      hRslt = bus.oRspRslt;
      chk("bp.rslt1", hRslt, 32'h101);
      #1;
      chk("bp.full", bus.oReqRdy, 2'b00);
      step();
      chk("bp.hold.tag", bus.oRspTag, 4'h1);
      chk("bp.hold.rslt", bus.oRspRslt, 32'h101);
      bus.iRspRdy = 1'b1;
      #1;
      chk("bp.resume", bus.oReqRdy, 2'b01);
      step();
      bus.iReqVld = 2'b00;
      chk("bp.tag2", bus.oRspTag, 4'h2);
      chk("bp.rslt2", bus.oRspRslt, 32'h102);
      step();
      chk("bp.vld3", bus.oRspVld, 1'b1);
      chk("bp.tag3", bus.oRspTag, 4'h3);
      chk("bp.rslt3", bus.oRspRslt, 32'h103);
      step();
      chk("bp.empty", bus.oRspVld, 1'b0);

      // ---- flush with two ops in flight ----
      bus.iRspRdy = 1'b0;
      setLane(0, 2'b00, 32'hFFFF_FFFF, 32'h1, 4'h5);
      setLane(1, 2'b00, 32'hFFFF_FFFF, 32'h2, 4'h6);
      bus.iReqVld = 2'b01;
      step();
      bus.iReqVld = 2'b10;
      step();
      bus.iReqVld = 2'b11;
      bus.iFlush  = 1'b1;
      #1;
      chk("fl.rdy", bus.oReqRdy, 2'b00);
      step();
      bus.iFlush  = 1'b0;
      bus.iReqVld = 2'b00;
      bus.iRspRdy = 1'b1;
      chk("fl.vld", bus.oRspVld, 1'b0);
      step();
      chk("fl.none", bus.oRspVld, 1'b0);

      // ---- reset mid-operation; last grant lane 0 leaves pointer at 1 ----
      bus.iRspRdy = 1'b0;
      bus.iReqVld = 2'b10;
      step();
      bus.iReqVld = 2'b01;
      step();
      iRst        = 1'b1;
      bus.iReqVld = 2'b11;
      #1;
      chk("mr.rdy", bus.oReqRdy, 2'b00);
      step();
      iRst = 1'b0;
      chkRspZero("mr");
      bus.iRspRdy = 1'b1;
      #1;
      chk("mr.grant", bus.oReqRdy, 2'b01);
      step();
      bus.iReqVld = 2'b00;
      chk("mr.lat", bus.oRspVld, 1'b0);
      step();
      chk("mr.vld", bus.oRspVld, 1'b1);
      chk("mr.src", bus.oRspSrc, 1'b0);
      chk("mr.tag", bus.oRspTag, 4'h5);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", compCnt, failCnt);
      $finish;
   end
endmodule
`default_nettype wire
